// File: rtl/ps2_keypad_decoder_if.sv
// PS/2 pins plus the key-code/strobe outputs of the keypad decoder.
interface ps2_keypad_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] data_out;
  logic        sel;
  logic        frame_err;

  modport master (output ps2_clk, ps2_data, input data_out, sel, frame_err);
  modport slave  (input ps2_clk, ps2_data, output data_out, sel, frame_err);
endinterface

// File: rtl/ps2_keypad_decoder.sv
// PS/2 set-2 keypad receiver: frames bytes, tracks E0/F0 prefixes and emits
// calculator key codes 0-14 with a fixed-width sel strobe.
module ps2_keypad_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SEL_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_keypad_decoder_if.slave  bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {R_IDLE, R_RECV, R_CHECK} rx_state_t;
  typedef enum logic {S_IDLE, S_HIGH} st_state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall_q, bit_q;
  rx_state_t     rx_state, rx_next;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic [TW-1:0] tcnt;
  logic          ext, brk;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          err_q;
  logic          frame_ok, map_hit;
  logic [3:0]    map_code;
  logic [7:0]    rx_byte;
  st_state_t     st_state, st_next;
  logic [7:0]    scnt;
  logic [10:0]   data_q;
  logic          sel_q;

  // Sync chains preset high so release from reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_data};
      fall_q   <= clk_sync[2] & ~clk_sync[1];
      bit_q    <= dat_sync[1];
    end
  end

  assign rx_byte  = frame[7:0];
  assign frame_ok = frame[9] & (^frame[8:0]);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (fall_q && !bit_q) rx_next = R_RECV;
      R_RECV: begin
        if (fall_q && bit_idx == 4'd10)                     rx_next = R_CHECK;
        else if (!fall_q && tcnt == TW'(TIMEOUT_CYCLES - 1)) rx_next = R_IDLE;
      end
      R_CHECK: rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    map_hit  = 1'b1;
    map_code = '0;
    if (ext) begin
      case (rx_byte)
        8'h4A:   map_code = 4'd13;
        8'h5A:   map_code = 4'd14;
        default: map_hit  = 1'b0;
      endcase
    end else begin
      case (rx_byte)
        8'h45, 8'h70: map_code = 4'd0;
        8'h16, 8'h69: map_code = 4'd1;
        8'h1E, 8'h72: map_code = 4'd2;
        8'h26, 8'h7A: map_code = 4'd3;
        8'h25, 8'h6B: map_code = 4'd4;
        8'h2E, 8'h73: map_code = 4'd5;
        8'h36, 8'h74: map_code = 4'd6;
        8'h3D, 8'h6C: map_code = 4'd7;
        8'h3E, 8'h75: map_code = 4'd8;
        8'h46, 8'h7D: map_code = 4'd9;
        8'h79:        map_code = 4'd10;
        8'h4E, 8'h7B: map_code = 4'd11;
        8'h7C:        map_code = 4'd12;
        8'h5A:        map_code = 4'd14;
        default:      map_hit  = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state  <= R_IDLE;
      bit_idx   <= '0;
      frame     <= '0;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      err_q     <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      key_valid <= 1'b0;
      err_q     <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          bit_idx <= 4'd1;
          tcnt    <= '0;
        end
        R_RECV: begin
          if (fall_q) begin
            frame   <= {bit_q, frame[9:1]};
            bit_idx <= bit_idx + 4'd1;
            tcnt    <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        R_CHECK: begin
          if (!frame_ok) begin
            err_q <= 1'b1;
            ext   <= 1'b0;
            brk   <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk <= 1'b1;
          end else begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_valid <= map_hit & ~brk;
            key_code  <= map_code;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_next = st_state;
    case (st_state)
      S_IDLE:  if (key_valid) st_next = S_HIGH;
      S_HIGH:  if (scnt == 8'd1) st_next = S_IDLE;
      default: st_next = S_IDLE;
    endcase
  end

  // data_out only loads from S_IDLE, so it is frozen for the whole strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_state <= S_IDLE;
      scnt     <= '0;
      data_q   <= '0;
      sel_q    <= 1'b0;
    end else begin
      st_state <= st_next;
      case (st_state)
        S_IDLE: begin
          if (key_valid) begin
            data_q <= {7'd0, key_code};
            sel_q  <= 1'b1;
            scnt   <= 8'(SEL_CYCLES);
          end
        end
        S_HIGH: begin
          scnt <= scnt - 8'd1;
          if (scnt == 8'd1) sel_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.sel       = sel_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Self-checking bench: directed key sequences plus random PS/2 traffic against
// a table-driven scan-code model.
module tb_ps2_keypad_decoder;
  localparam int unsigned SEL  = 4;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_keypad_decoder_if bus ();

  ps2_keypad_decoder #(.TIMEOUT_CYCLES(5000), .SEL_CYCLES(SEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_stop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: scan-code tables and prefix flags.
  int unsigned plain_map[int];
  int unsigned ext_map[int];
  int unsigned exp_q[$];
  bit m_ext = 1'b0, m_brk = 1'b0;
  int unsigned exp_errs = 0, seen_errs = 0;

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_errs++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!m_brk) begin
        if (m_ext && ext_map.exists(int'(b)))        exp_q.push_back(ext_map[int'(b)]);
        else if (!m_ext && plain_map.exists(int'(b))) exp_q.push_back(plain_map[int'(b)]);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int unsigned nbits, input int unsigned gap);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < int'(nbits); i++) begin
      bus.ps2_data = fr[i];
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      if (i == 10) last_stop = cyc;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic key(input logic [7:0] b);
    model_frame(b, 1'b1);
    send_frame(b, 1'b0, 11, 20);
  endtask

  // Output monitor, sampled on the falling clock edge.
  bit          prev_sel = 1'b0;
  bit          abort = 1'b0;
  int unsigned width = 0;
  logic [10:0] held = '0;

  always @(negedge clk) begin
    if (bus.sel && !prev_sel) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sel", 32'd1, 32'd0);
      end else begin
        check("code", 32'(bus.data_out), 32'(exp_q.pop_front()));
        check("sel_latency", cyc - last_stop, 32'd6);
      end
      width = 1;
      held  = bus.data_out;
    end else if (bus.sel) begin
      width++;
      check("data_stable", 32'(bus.data_out), 32'(held));
    end else if (prev_sel) begin
      if (!abort) check("sel_width", width, SEL);
      abort = 1'b0;
    end
    if (bus.frame_err) begin
      seen_errs++;
      check("err_latency", cyc - last_stop, 32'd5);
    end
    prev_sel = bus.sel;
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [0:25] = '{8'h45, 8'h70, 8'h16, 8'h69, 8'h1E, 8'h72, 8'h26, 8'h7A,
                              8'h25, 8'h6B, 8'h2E, 8'h73, 8'h36, 8'h74, 8'h3D, 8'h6C,
                              8'h3E, 8'h75, 8'h46, 8'h7D, 8'h79, 8'h4E, 8'h7B, 8'h7C,
                              8'h5A, 8'h4A};

  initial begin
    logic [7:0] b;
    int unsigned r;
    bit seen;

    plain_map[8'h45] = 0;  plain_map[8'h70] = 0;  plain_map[8'h16] = 1;  plain_map[8'h69] = 1;
    plain_map[8'h1E] = 2;  plain_map[8'h72] = 2;  plain_map[8'h26] = 3;  plain_map[8'h7A] = 3;
    plain_map[8'h25] = 4;  plain_map[8'h6B] = 4;  plain_map[8'h2E] = 5;  plain_map[8'h73] = 5;
    plain_map[8'h36] = 6;  plain_map[8'h74] = 6;  plain_map[8'h3D] = 7;  plain_map[8'h6C] = 7;
    plain_map[8'h3E] = 8;  plain_map[8'h75] = 8;  plain_map[8'h46] = 9;  plain_map[8'h7D] = 9;
    plain_map[8'h79] = 10; plain_map[8'h4E] = 11; plain_map[8'h7B] = 11; plain_map[8'h7C] = 12;
    plain_map[8'h5A] = 14;
    ext_map[8'h4A] = 13;   ext_map[8'h5A] = 14;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b0;
    wait_cyc(5);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b1;
    wait_cyc(10);

    key(8'h16);
    check("t1_errs", seen_errs, 32'd0);

    key(8'h45); key(8'hF0); key(8'h45); key(8'h7B); key(8'hF0); key(8'h7B);

    key(8'hE0); key(8'h4A); key(8'hE0); key(8'h5A); key(8'h5A);
    key(8'h4A);
    check("hold_after_4a", 32'(bus.data_out), 32'd14);

    model_frame(8'h16, 1'b0);
    send_frame(8'h16, 1'b1, 11, 20);
    key(8'h1E);
    check("bad_parity_errs", seen_errs, exp_errs);

    send_frame(8'h26, 1'b0, 6, 6000);
    key(8'h26);
    check("timeout_errs", seen_errs, exp_errs);

    model_frame(8'h46, 1'b1);
    send_frame(8'h46, 1'b0, 11, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.sel) begin
        seen = 1'b1;
        break;
      end
      wait_cyc(1);
    end
    check("sel_before_reset", 32'(seen), 32'd1);
    abort = 1'b1;
    rst = 1'b0;
    wait_cyc(1);
    check("reset_sel", 32'(bus.sel), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(10);
    key(8'h79);

    for (int n = 0; n < 100; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(2, 10), 5100);
      end else if (r < 13) begin
        b = 8'($urandom);
        model_frame(b, 1'b0);
        send_frame(b, 1'b1, 11, 20 + $urandom_range(0, 10));
      end else begin
        if (r < 33)      b = 8'hE0;
        else if (r < 45) b = 8'hF0;
        else if (r < 55) b = 8'($urandom);
        else             b = pool[$urandom_range(0, 25)];
        model_frame(b, 1'b1);
        send_frame(b, 1'b0, 11, 20 + $urandom_range(0, 10));
      end
    end

    wait_cyc(30);
    check("pending_keys", exp_q.size(), 32'd0);
    check("total_errs", seen_errs, exp_errs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
